// File: rtl/dmem_pkg.sv
// dmem_pkg: shared codes, FSM state type and sizing helper for the data_mem arbiter.
package dmem_pkg;
    localparam logic [2:0] LD_NONE = 3'b000;
    localparam logic [2:0] LD_WORD = 3'b001;
    localparam logic [1:0] ST_NONE = 2'b00;
    localparam logic [1:0] ST_WORD = 2'b01;
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} arb_state_t;
    function automatic int grant_idx_w(input int num_req);
        return (num_req < 2) ? 1 : $clog2(num_req);
    endfunction
endpackage

// File: rtl/dmem_arbiter_rr.sv
// dmem_arbiter_rr: combinational round-robin pick starting after last_grant.
//   req_valid    in  per-requester valid
//   last_grant   in  index of the most recently served requester
//   grant_onehot out one-hot grant, zero when nothing is valid
//   grant_idx    out binary index of the grant
//   any_req      out some requester is valid
module rr_arbiter
    import dmem_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int GW      = grant_idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [GW-1:0]      last_grant,
    output logic [NUM_REQ-1:0] grant_onehot,
    output logic [GW-1:0]      grant_idx,
    output logic               any_req
);
    always_comb begin
        int w_idx;
        w_idx = 0;
        grant_idx = '0;
        any_req = |req_valid;
        // Walk the priority order backwards so the closest requester after last_grant wins.
        for (int k = NUM_REQ; k >= 1; k--) begin
            w_idx = (int'(last_grant) + k) % NUM_REQ;
            if (req_valid[w_idx]) grant_idx = GW'(w_idx);
        end
        grant_onehot = any_req ? NUM_REQ'(1) << grant_idx : '0;
    end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin sharing of single-ported data_mem, one access per 3 cycles.
//   clk, n_reset              clock, async active-low reset
//   req_valid/req_ready       per-requester handshake (ready one-hot, IDLE only)
//   req_addr/wdata/load/store packed per-requester request fields
//   resp_valid/resp_rdata     one-cycle one-hot completion with load data
//   address/dmem_wdata/load_control/store_control/dmem_rdata  data_mem port
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int n         = 32,
    parameter int dmem_size = 7,
    parameter int NUM_REQ   = 2
) (
    input  logic                    clk,
    input  logic                    n_reset,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*(n-2)-1:0] req_addr,
    input  logic [NUM_REQ*32-1:0]   req_wdata,
    input  logic [NUM_REQ*3-1:0]    req_load,
    input  logic [NUM_REQ*2-1:0]    req_store,
    output logic [NUM_REQ-1:0]      resp_valid,
    output logic [31:0]             resp_rdata,
    output logic [n-3:0]            address,
    output logic [31:0]             dmem_wdata,
    output logic [2:0]              load_control,
    output logic [1:0]              store_control,
    input  logic [31:0]             dmem_rdata
);
    localparam int AW = n - 2;
    localparam int GW = grant_idx_w(NUM_REQ);
    arb_state_t         r_state;
    logic [GW-1:0]      r_last_grant, r_grant;
    logic [NUM_REQ-1:0] r_resp_valid;
    logic [31:0]        r_resp_rdata, r_wdata;
    logic [AW-1:0]      r_addr;
    logic [2:0]         r_load;
    logic [1:0]         r_store;
    logic [NUM_REQ-1:0] w_grant_onehot;
    logic [GW-1:0]      w_grant_idx;
    logic               w_any_req;
    logic [AW-1:0]      w_addr_sel;
    logic [31:0]        w_wdata_sel;
    logic [2:0]         w_load_sel;
    logic [1:0]         w_store_sel;
    rr_arbiter #(.NUM_REQ(NUM_REQ), .GW(GW)) u_rr (
        .req_valid    (req_valid),
        .last_grant   (r_last_grant),
        .grant_onehot (w_grant_onehot),
        .grant_idx    (w_grant_idx),
        .any_req      (w_any_req)
    );
    assign w_addr_sel  = req_addr[int'(w_grant_idx)*AW +: AW];
    assign w_wdata_sel = req_wdata[int'(w_grant_idx)*32 +: 32];
    assign w_load_sel  = req_load[int'(w_grant_idx)*3 +: 3];
    assign w_store_sel = req_store[int'(w_grant_idx)*2 +: 2];
    // Gated by n_reset so no handshake is offered while reset is held.
    assign req_ready     = (r_state == IDLE && n_reset) ? w_grant_onehot : '0;
    assign resp_valid    = r_resp_valid;
    assign resp_rdata    = r_resp_rdata;
    // Word index lives in the low dmem_size bits; upper bits pass through untouched.
    assign address       = {r_addr[AW-1:dmem_size], r_addr[dmem_size-1:0]};
    assign dmem_wdata    = r_wdata;
    assign load_control  = r_load;
    assign store_control = r_store;
    // Memory-side registers hold the request only for the ACCESS cycle and are zero otherwise.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_state      <= IDLE;
            r_last_grant <= GW'(NUM_REQ - 1);
            r_grant      <= '0;
            r_resp_valid <= '0;
            r_resp_rdata <= '0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_load       <= LD_NONE;
            r_store      <= ST_NONE;
        end else begin
            case (r_state)
                IDLE: if (w_any_req) begin
                    r_grant <= w_grant_idx;
                    r_addr  <= w_addr_sel;
                    r_wdata <= w_wdata_sel;
                    r_store <= w_store_sel;
                    // A store suppresses any simultaneous load.
                    r_load  <= (w_store_sel != ST_NONE) ? LD_NONE : w_load_sel;
                    r_state <= ACCESS;
                end
                ACCESS: begin
                    r_resp_valid <= NUM_REQ'(1) << r_grant;
                    r_resp_rdata <= (r_load != LD_NONE) ? dmem_rdata : '0;
                    r_addr       <= '0;
                    r_wdata      <= '0;
                    r_load       <= LD_NONE;
                    r_store      <= ST_NONE;
                    r_state      <= RESP;
                end
                RESP: begin
                    r_resp_valid <= '0;
                    r_resp_rdata <= '0;
                    r_last_grant <= r_grant;
                    r_state      <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scenario bench for dmem_arbiter with a behavioural data_mem.
module tb_dmem_arbiter;
    import dmem_pkg::*;
    localparam int AW = 30;
    localparam int NR = 2;
    logic clk = 0;
    logic n_reset = 0;
    logic [NR-1:0] req_valid = '0;
    logic [NR-1:0] req_ready;
    logic [NR*AW-1:0] req_addr = '0;
    logic [NR*32-1:0] req_wdata = '0;
    logic [NR*3-1:0] req_load = '0;
    logic [NR*2-1:0] req_store = '0;
    logic [NR-1:0] resp_valid;
    logic [31:0] resp_rdata, dmem_wdata, dmem_rdata;
    logic [AW-1:0] address;
    logic [2:0] load_control;
    logic [1:0] store_control;
    logic [31:0] mem [0:127];
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.n(32), .dmem_size(7), .NUM_REQ(NR)) dut (
        .clk(clk), .n_reset(n_reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_load(req_load), .req_store(req_store),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .address(address), .dmem_wdata(dmem_wdata),
        .load_control(load_control), .store_control(store_control),
        .dmem_rdata(dmem_rdata)
    );

    assign dmem_rdata = mem[address[6:0]];
    always @(posedge clk) if (store_control != ST_NONE) mem[address[6:0]] <= dmem_wdata;

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [31:0] d,
                           input logic [2:0] ld, input logic [1:0] st);
        req_addr[i*AW +: AW] = a;
        req_wdata[i*32 +: 32] = d;
        req_load[i*3 +: 3] = ld;
        req_store[i*2 +: 2] = st;
    endtask

    task automatic do_reset();
        n_reset = 0;
        req_valid = '0;
        repeat (2) @(negedge clk);
        n_reset = 1;
    endtask

    task automatic write_mem(input logic [AW-1:0] a, input logic [31:0] d);
        set_req(0, a, d, LD_NONE, ST_WORD);
        req_valid = 2'b01;
        @(negedge clk);
        req_valid = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        n_reset = 0;
        req_valid = 2'b11;
        @(negedge clk);
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready got=%b want=00", req_ready); end
        checks++; if (resp_valid !== 2'b00) begin errors++; $display("FAIL reset_resp_valid got=%b want=00", resp_valid); end
        checks++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h want=0", resp_rdata); end
        checks++; if (address !== 30'h0) begin errors++; $display("FAIL reset_address got=%h want=0", address); end
        checks++; if (dmem_wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata got=%h want=0", dmem_wdata); end
        checks++; if (load_control !== LD_NONE) begin errors++; $display("FAIL reset_load got=%b want=000", load_control); end
        checks++; if (store_control !== ST_NONE) begin errors++; $display("FAIL reset_store got=%b want=00", store_control); end
        req_valid = '0;
    endtask

    task automatic test_store();
        do_reset();
        set_req(0, 30'd20, 32'h55, LD_NONE, ST_WORD);
        req_valid = 2'b01;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL store_ready got=%b want=01", req_ready); end
        @(negedge clk);
        req_valid = '0;
        checks++; if (address !== 30'd20) begin errors++; $display("FAIL store_address got=%0d want=20", address); end
        checks++; if (store_control !== ST_WORD) begin errors++; $display("FAIL store_ctrl got=%b want=01", store_control); end
        checks++; if (dmem_wdata !== 32'h55) begin errors++; $display("FAIL store_wdata got=%h want=55", dmem_wdata); end
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL store_ready_access got=%b want=00", req_ready); end
        @(negedge clk);
        checks++; if (mem[20] !== 32'h55) begin errors++; $display("FAIL store_mem got=%h want=55", mem[20]); end
        checks++; if (resp_valid !== 2'b01) begin errors++; $display("FAIL store_resp got=%b want=01", resp_valid); end
        checks++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL store_rdata got=%h want=0", resp_rdata); end
        @(negedge clk);
        checks++; if (resp_valid !== 2'b00) begin errors++; $display("FAIL store_resp_end got=%b want=00", resp_valid); end
    endtask

    task automatic test_load();
        set_req(1, 30'd20, 32'h0, LD_WORD, ST_NONE);
        req_valid = 2'b10;
        #1;
        checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL load_ready got=%b want=10", req_ready); end
        @(negedge clk);
        req_valid = '0;
        checks++; if (load_control !== LD_WORD) begin errors++; $display("FAIL load_ctrl got=%b want=001", load_control); end
        checks++; if (store_control !== ST_NONE) begin errors++; $display("FAIL load_store_ctrl got=%b want=00", store_control); end
        checks++; if (address !== 30'd20) begin errors++; $display("FAIL load_address got=%0d want=20", address); end
        @(negedge clk);
        checks++; if (resp_valid !== 2'b10) begin errors++; $display("FAIL load_resp got=%b want=10", resp_valid); end
        checks++; if (resp_rdata !== 32'h55) begin errors++; $display("FAIL load_rdata got=%h want=55", resp_rdata); end
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_ready, exp_resp, who;
        do_reset();
        set_req(0, 30'd1, 32'h0, LD_NONE, ST_NONE);
        set_req(1, 30'd2, 32'h0, LD_NONE, ST_NONE);
        req_valid = 2'b11;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            who = ((c / 3) % 2 == 0) ? 2'b01 : 2'b10;
            exp_ready = (c % 3 == 0) ? who : 2'b00;
            exp_resp = (c % 3 == 2) ? who : 2'b00;
            checks++; if (req_ready !== exp_ready) begin errors++; $display("FAIL rr_ready c=%0d got=%b want=%b", c, req_ready, exp_ready); end
            checks++; if (resp_valid !== exp_resp) begin errors++; $display("FAIL rr_resp c=%0d got=%b want=%b", c, resp_valid, exp_resp); end
        end
        req_valid = '0;
        @(negedge clk);
    endtask

    task automatic test_conflict();
        do_reset();
        write_mem(30'd7, 32'h1234);
        set_req(0, 30'd7, 32'hA5, LD_WORD, ST_WORD);
        req_valid = 2'b01;
        @(negedge clk);
        req_valid = '0;
        checks++; if (load_control !== LD_NONE) begin errors++; $display("FAIL conflict_load got=%b want=000", load_control); end
        checks++; if (store_control !== ST_WORD) begin errors++; $display("FAIL conflict_store got=%b want=01", store_control); end
        @(negedge clk);
        checks++; if (mem[7] !== 32'hA5) begin errors++; $display("FAIL conflict_mem got=%h want=a5", mem[7]); end
        checks++; if (resp_valid !== 2'b01) begin errors++; $display("FAIL conflict_resp got=%b want=01", resp_valid); end
        checks++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL conflict_rdata got=%h want=0", resp_rdata); end
        @(negedge clk);
    endtask

    task automatic test_reset_abort();
        do_reset();
        write_mem(30'd9, 32'h3);
        set_req(0, 30'd9, 32'h77, LD_NONE, ST_WORD);
        set_req(1, 30'd3, 32'h0, LD_NONE, ST_NONE);
        req_valid = 2'b01;
        @(negedge clk);
        checks++; if (store_control !== ST_WORD) begin errors++; $display("FAIL abort_pre_store got=%b want=01", store_control); end
        #2 n_reset = 0;
        #1;
        checks++; if (store_control !== ST_NONE) begin errors++; $display("FAIL abort_store got=%b want=00", store_control); end
        checks++; if (address !== 30'h0) begin errors++; $display("FAIL abort_address got=%h want=0", address); end
        req_valid = 2'b11;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++; if (resp_valid !== 2'b00) begin errors++; $display("FAIL abort_resp c=%0d got=%b want=00", c, resp_valid); end
        end
        checks++; if (mem[9] !== 32'h3) begin errors++; $display("FAIL abort_mem got=%h want=3", mem[9]); end
        n_reset = 1;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL abort_first_grant got=%b want=01", req_ready); end
        req_valid = '0;
        @(negedge clk);
    endtask

    task automatic test_drop();
        do_reset();
        set_req(0, 30'd20, 32'h0, LD_WORD, ST_NONE);
        set_req(1, 30'd4, 32'h0, LD_WORD, ST_NONE);
        req_valid = 2'b01;
        @(negedge clk);
        req_valid = 2'b11;
        #1;
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL drop_ready_access got=%b want=00", req_ready); end
        @(negedge clk);
        req_valid = '0;
        #1;
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL drop_ready_resp got=%b want=00", req_ready); end
        checks++; if (resp_valid !== 2'b01) begin errors++; $display("FAIL drop_resp got=%b want=01", resp_valid); end
        checks++; if (resp_rdata !== 32'h55) begin errors++; $display("FAIL drop_rdata got=%h want=55", resp_rdata); end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++; if (resp_valid !== 2'b00) begin errors++; $display("FAIL drop_no_resp c=%0d got=%b want=00", c, resp_valid); end
            checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL drop_no_ready c=%0d got=%b want=00", c, req_ready); end
        end
    endtask

    initial begin
        test_reset();
        test_store();
        test_load();
        test_round_robin();
        test_conflict();
        test_reset_abort();
        test_drop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
